packet_switch_tx_dbg_pkt_tap: RTL

Per-channel traffic tap that feeds the TX debug statistics CSRs. Snoops the valid/ready/last handshakes of up to NUM_CH AXI-Stream links (DMA→igr_wadj, igr_wadj→igr_arb, igr_arb→HSSI) and produces each channel's `cnt_next` from the CSR's current `cnt_prev`. It sits directly upstream of the TX debug counter interface, which loads `cnt_next` into its counter registers every cycle. It also flags AXI-S protocol violations per channel.

---
 rtl/packet_switch_dbg_pkg.sv | 12 +
 rtl/packet_switch_tx_dbg_pkt_tap_if.sv | 11 +
 rtl/packet_switch_dbg_link_tap.sv | 110 +++++++++++
 rtl/packet_switch_tx_dbg_pkt_tap.sv | 43 ++++
 4 files changed

// File: rtl/packet_switch_dbg_pkg.sv
// Shared types and constants for the TX debug packet tap.
package packet_switch_dbg_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } pkt_state_e;

    localparam int CNT_MODE_PKT  = 0;
    localparam int CNT_MODE_BEAT = 1;

endpackage

// File: rtl/packet_switch_tx_dbg_pkt_tap_if.sv
// Snooped AXI-Stream handshake bundle for all monitored links.
interface packet_switch_tx_dbg_pkt_tap_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0] mon_tvalid;
    logic [NUM_CH-1:0] mon_tready;
    logic [NUM_CH-1:0] mon_tlast;

    modport master (output mon_tvalid, output mon_tready, output mon_tlast);
    modport slave  (input  mon_tvalid, input  mon_tready, input  mon_tlast);
endinterface

// File: rtl/packet_switch_dbg_link_tap.sv
// One link's tap: increment capture, saturating/wrapping next-count adder,
// SOP/EOP tracker and tvalid-withdrawal checker.
module packet_switch_dbg_link_tap
    import packet_switch_dbg_pkg::*;
#(
    parameter int CNTR_WIDTH = 32,
    parameter int COUNT_MODE = CNT_MODE_PKT,
    parameter bit SATURATE   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tvalid,
    input  logic                  tready,
    input  logic                  tlast,
    input  logic                  cnt_en,
    input  logic                  err_clr,
    input  logic [CNTR_WIDTH-1:0] cnt_prev,
    output logic [CNTR_WIDTH-1:0] cnt_next,
    output logic                  proto_err,
    output logic                  in_pkt
);

    localparam logic [CNTR_WIDTH-1:0] CNT_ONE = {{(CNTR_WIDTH-1){1'b0}}, 1'b1};

    logic       acc_s;
    logic       inc_s;
    logic       inc_q_r;
    logic       pend_r;
    logic       err_set_s;
    logic       proto_err_r;
    logic       in_pkt_r;
    pkt_state_e state_r;
    pkt_state_e state_s;

    assign acc_s     = tvalid & tready;
    assign err_set_s = pend_r & ~tvalid;

    // Increment event selection by count mode
    always_comb begin
        inc_s = 1'b0;
        if (COUNT_MODE == CNT_MODE_BEAT) begin
            inc_s = cnt_en & acc_s;
        end else begin
            inc_s = cnt_en & acc_s & tlast;
        end
    end

    // Next counter value; stays combinational because the CSR reloads every cycle
    always_comb begin
        cnt_next = cnt_prev;
        if (inc_q_r) begin
            if (SATURATE && (&cnt_prev)) begin
                cnt_next = cnt_prev;
            end else begin
                cnt_next = cnt_prev + CNT_ONE;
            end
        end else begin
            cnt_next = cnt_prev;
        end
    end

    // Packet FSM next-state: single-beat packets never leave IDLE
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (acc_s && !tlast) begin
                    state_s = IN_PKT;
                end else begin
                    state_s = IDLE;
                end
            end
            IN_PKT: begin
                if (acc_s && tlast) begin
                    state_s = IDLE;
                end else begin
                    state_s = IN_PKT;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, increment capture, pending tracker and sticky error (set beats clear)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            in_pkt_r    <= 1'b0;
            inc_q_r     <= 1'b0;
            pend_r      <= 1'b0;
            proto_err_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            in_pkt_r <= (state_s == IN_PKT);
            inc_q_r  <= inc_s;
            pend_r   <= tvalid & ~tready;
            if (err_set_s) begin
                proto_err_r <= 1'b1;
            end else if (err_clr) begin
                proto_err_r <= 1'b0;
            end else begin
                proto_err_r <= proto_err_r;
            end
        end
    end

    assign proto_err = proto_err_r;
    assign in_pkt    = in_pkt_r;

endmodule

// File: rtl/packet_switch_tx_dbg_pkt_tap.sv
// TX debug traffic tap: per-link next-count generation for the statistics CSRs
// plus packet-state and protocol-violation flags.
module packet_switch_tx_dbg_pkt_tap
    import packet_switch_dbg_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int CNTR_WIDTH = 32,
    parameter int COUNT_MODE = CNT_MODE_PKT,
    parameter bit SATURATE   = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    packet_switch_tx_dbg_pkt_tap_if.slave mon,
    input  logic                         cnt_en,
    input  logic [NUM_CH*CNTR_WIDTH-1:0] cnt_prev,
    output logic [NUM_CH*CNTR_WIDTH-1:0] cnt_next,
    output logic [NUM_CH-1:0]            proto_err,
    input  logic [NUM_CH-1:0]            err_clr,
    output logic [NUM_CH-1:0]            in_pkt
);

    genvar g;
    for (g = 0; g < NUM_CH; g++) begin : g_link
        packet_switch_dbg_link_tap #(
            .CNTR_WIDTH (CNTR_WIDTH),
            .COUNT_MODE (COUNT_MODE),
            .SATURATE   (SATURATE)
        ) u_link (
            .clk       (clk),
            .rst       (rst),
            .tvalid    (mon.mon_tvalid[g]),
            .tready    (mon.mon_tready[g]),
            .tlast     (mon.mon_tlast[g]),
            .cnt_en    (cnt_en),
            .err_clr   (err_clr[g]),
            .cnt_prev  (cnt_prev[g*CNTR_WIDTH +: CNTR_WIDTH]),
            .cnt_next  (cnt_next[g*CNTR_WIDTH +: CNTR_WIDTH]),
            .proto_err (proto_err[g]),
            .in_pkt    (in_pkt[g])
        );
    end

endmodule
